// File: rtl/issue_scheduler.sv
// issue_scheduler: instruction buffer plus one/two-slot issue to Decode.
// Fetch pushes two instructions per cycle into a circular buffer. Slot A
// always carries the head. Slot B carries head+1 when the pair is free of
// hazards.
// Optional feature: define ISSUE_DUAL_EN to enable pairing into slot B.
// Without it the scheduler issues at most one instruction per cycle.
module issue_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr0,
  input  logic [31:0]              fetch_instr1,
  input  logic [31:0]              fetch_pc4_0,
  input  logic [31:0]              fetch_pc4_1,
  output logic                     fetch_ready,
  input  logic                     stall_d,
  input  logic                     flush,
  output logic                     issue_valid_a,
  output logic                     issue_valid_b,
  output logic [31:0]              issue_instr_a,
  output logic [31:0]              issue_instr_b,
  output logic [31:0]              issue_pc4_a,
  output logic [31:0]              issue_pc4_b,
  output logic                     dual_issue,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop_en;
  logic [1:0]    pop_n;

  // Space check uses the registered count only; same-cycle pops are not credited.
  assign fetch_ready = (count <= CW'(DEPTH - 2));
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop_en      = !stall_d && !flush;

  assign issue_valid_a = (count != '0);
  assign issue_instr_a = issue_valid_a ? instr_mem[head] : 32'd0;
  assign issue_pc4_a   = issue_valid_a ? pc4_mem[head]   : 32'd0;

`ifdef ISSUE_DUAL_EN
  logic [PW-1:0] head_p1;
  logic [PW-1:0] slot_idx  [2];
  logic [1:0]    slot_wr;
  logic [1:0]    slot_mem;
  logic [1:0]    slot_ctrl;
  logic [4:0]    slot_dest [2];
  logic [4:0]    b_rs;
  logic [4:0]    b_rt;
  logic          raw_hazard;
  logic          waw_hazard;
  logic          hazard;

  assign head_p1     = head + PW'(1);
  assign slot_idx[0] = head;
  assign slot_idx[1] = head_p1;

  // Predecode of the two head entries: write, destination, memory and control class.
  for (genvar gi = 0; gi < 2; gi++) begin : g_predecode
    logic [5:0] op;
    logic [5:0] funct;
    assign op    = instr_mem[slot_idx[gi]][31:26];
    assign funct = instr_mem[slot_idx[gi]][5:0];
    assign slot_wr[gi]   = ((op == 6'h00) && (funct != 6'h08)) ||
                           ((op >= 6'h08) && (op <= 6'h0F)) ||
                           (op == 6'h23) || (op == 6'h03);
    assign slot_dest[gi] = (op == 6'h00) ? instr_mem[slot_idx[gi]][15:11] :
                           (op == 6'h03) ? 5'd31 :
                                           instr_mem[slot_idx[gi]][20:16];
    assign slot_mem[gi]  = (op == 6'h23) || (op == 6'h2B);
    assign slot_ctrl[gi] = ((op >= 6'h02) && (op <= 6'h05)) ||
                           ((op == 6'h00) && (funct == 6'h08));
  end

  // B source fields are compared conservatively, whatever the format.
  assign b_rs = instr_mem[head_p1][25:21];
  assign b_rt = instr_mem[head_p1][20:16];

  assign raw_hazard = slot_wr[0] && (slot_dest[0] != 5'd0) &&
                      ((slot_dest[0] == b_rs) || (slot_dest[0] == b_rt));
  assign waw_hazard = slot_wr[0] && slot_wr[1] && (slot_dest[0] != 5'd0) &&
                      (slot_dest[0] == slot_dest[1]);
  assign hazard     = raw_hazard || waw_hazard || (slot_mem[0] && slot_mem[1]) ||
                      slot_ctrl[0] || slot_ctrl[1];

  assign issue_valid_b = (count >= CW'(2)) && !hazard;
  assign issue_instr_b = issue_valid_b ? instr_mem[head_p1] : 32'd0;
  assign issue_pc4_b   = issue_valid_b ? pc4_mem[head_p1]   : 32'd0;
`else
  assign issue_valid_b = 1'b0;
  assign issue_instr_b = 32'd0;
  assign issue_pc4_b   = 32'd0;
`endif

  assign dual_issue = issue_valid_b;
  assign pop_n      = pop_en ? ({1'b0, issue_valid_a} + {1'b0, issue_valid_b}) : 2'd0;

  // Buffer storage: both fetched instructions land at tail and tail+1.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail]          <= fetch_instr0;
      pc4_mem[tail]            <= fetch_pc4_0;
      instr_mem[tail + PW'(1)] <= fetch_instr1;
      pc4_mem[tail + PW'(1)]   <= fetch_pc4_1;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      if (push) tail <= tail + PW'(2);
      count <= count + (push ? CW'(2) : CW'(0)) - CW'(pop_n);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed scenarios followed by random
// traffic, checked against a queue-based reference model of the buffer.
module tb_issue_scheduler;

`ifdef ISSUE_DUAL_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_instr0, fetch_instr1, fetch_pc4_0, fetch_pc4_1;
  logic        fetch_ready;
  logic        stall_d, flush;
  logic        issue_valid_a, issue_valid_b, dual_issue;
  logic [31:0] issue_instr_a, issue_instr_b, issue_pc4_a, issue_pc4_b;
  logic [2:0]  count;

  issue_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
    .fetch_pc4_0(fetch_pc4_0), .fetch_pc4_1(fetch_pc4_1), .fetch_ready(fetch_ready),
    .stall_d(stall_d), .flush(flush),
    .issue_valid_a(issue_valid_a), .issue_valid_b(issue_valid_b),
    .issue_instr_a(issue_instr_a), .issue_instr_b(issue_instr_b),
    .issue_pc4_a(issue_pc4_a), .issue_pc4_b(issue_pc4_b),
    .dual_issue(dual_issue), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   exp_va, exp_vb, exp_ready;
  int   dual_seen = 0;

  // Reference predecode: destination register written, or -1 if none.
  function automatic int dest_of(logic [31:0] x);
    int op;
    op = int'(x[31:26]);
    if (op == 0) return (x[5:0] == 6'h08) ? -1 : int'(x[15:11]);
    if (op >= 8 && op <= 15) return int'(x[20:16]);
    if (op == 'h23) return int'(x[20:16]);
    if (op == 3) return 31;
    return -1;
  endfunction

  function automatic bit is_mem(logic [31:0] x);
    return (x[31:26] == 6'h23) || (x[31:26] == 6'h2B);
  endfunction

  function automatic bit is_ctrl(logic [31:0] x);
    int op;
    op = int'(x[31:26]);
    return (op >= 2 && op <= 5) || (op == 0 && x[5:0] == 6'h08);
  endfunction

  function automatic bit can_pair(logic [31:0] a, logic [31:0] b);
    int da, db;
    da = dest_of(a);
    db = dest_of(b);
    if (is_ctrl(a) || is_ctrl(b)) return 1'b0;
    if (is_mem(a) && is_mem(b)) return 1'b0;
    if (da > 0 && (da == int'(b[25:21]) || da == int'(b[20:16]))) return 1'b0;
    if (da > 0 && da == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model predicts for the current state.
  task automatic check_outputs();
    exp_ready = (DEPTH - q.size()) >= 2;
    exp_va    = q.size() >= 1;
    exp_vb    = DUAL_EN && q.size() >= 2 && can_pair(q[0].instr, q[1].instr);
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
    chk("count", 32'(count), 32'(q.size()));
    chk("valid_a", 32'(issue_valid_a), 32'(exp_va));
    chk("valid_b", 32'(issue_valid_b), 32'(exp_vb));
    chk("dual_issue", 32'(dual_issue), 32'(exp_vb));
    chk("instr_a", issue_instr_a, exp_va ? q[0].instr : 32'd0);
    chk("pc4_a", issue_pc4_a, exp_va ? q[0].pc4 : 32'd0);
    chk("instr_b", issue_instr_b, exp_vb ? q[1].instr : 32'd0);
    chk("pc4_b", issue_pc4_b, exp_vb ? q[1].pc4 : 32'd0);
  endtask

  // One clock cycle: drive, check, clock, advance the model.
  task automatic step(input bit fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input bit st, input bit fl);
    int npop;
    bit pushed;
    fetch_valid  = fv;
    fetch_instr0 = i0;
    fetch_instr1 = i1;
    fetch_pc4_0  = p0;
    fetch_pc4_1  = p1;
    stall_d      = st;
    flush        = fl;
    #3;
    check_outputs();
    if (dual_issue) dual_seen++;
    npop   = (!st && !fl) ? (int'(exp_va) + int'(exp_vb)) : 0;
    pushed = fv && exp_ready && !fl;
    $display("t=%0t fv=%0d st=%0d fl=%0d A=%0d:%h B=%0d:%h cnt=%0d pop=%0d push=%0d",
             $time, fv, st, fl, issue_valid_a, issue_instr_a, issue_valid_b, issue_instr_b,
             count, npop, pushed);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      for (int k = 0; k < npop; k++) void'(q.pop_front());
      if (pushed) begin
        q.push_back('{instr: i0, pc4: p0});
        q.push_back('{instr: i1, pc4: p1});
      end
    end
    #1;
  endtask

  task automatic idle(input bit st);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, st, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [12];
    logic [5:0] fns [4];
    logic [31:0] x;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0D, 6'h23, 6'h2B, 6'h02, 6'h04, 6'h03, 6'h20};
    fns = '{6'h21, 6'h20, 6'h08, 6'h2A};
    x = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 5'd0, fns[$urandom_range(0, 3)]};
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_instr0 = '0; fetch_instr1 = '0;
    fetch_pc4_0 = '0; fetch_pc4_1 = '0; stall_d = 1'b0; flush = 1'b0;
    #1;
    check_outputs();
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Independent addu pair.
    step(1'b1, 32'h00221821, 32'h00E83021, 32'h104, 32'h108, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("dual_seen_first_pair", 32'(dual_seen != 0), 32'(DUAL_EN));

    // RAW-dependent pair, then lw/sw, then beq with an addu.
    step(1'b1, 32'h00221821, 32'h00652021, 32'h204, 32'h208, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    step(1'b1, 32'h8C220000, 32'hACC50004, 32'h304, 32'h308, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    step(1'b1, 32'h10220003, 32'h00E83021, 32'h404, 32'h408, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Stall with four pushes attempted: buffer fills, outputs hold.
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'h00221821 + 32'(k), 32'h00E83021 + 32'(k), 32'h500 + 32'(8*k),
           32'h504 + 32'(8*k), 1'b1, 1'b0);
    idle(1'b1);

    // Reach count 3 with a lw/sw head, then flush with a push offered.
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h8C220000, 32'hACC50004, 32'h604, 32'h608, 1'b1, 1'b0);
    step(1'b1, 32'h8C230000, 32'hACC60004, 32'h60C, 32'h610, 1'b1, 1'b0);
    idle(1'b0);
    chk("count_before_flush", 32'(count), 32'd3);
    step(1'b1, 32'h00221821, 32'h00E83021, 32'h704, 32'h708, 1'b0, 1'b1);
    idle(1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 9) < 7, rand_instr(), rand_instr(), $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);

    // Asynchronous reset in the middle of a cycle with a full-ish buffer.
    step(1'b1, 32'h00221821, 32'h00E83021, 32'h804, 32'h808, 1'b1, 1'b0);
    fetch_valid = 1'b0; stall_d = 1'b0;
    #2 rst_n = 1'b0;
    #1 q.delete();
    check_outputs();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h00221821, 32'h00E83021, 32'h904, 32'h908, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
